uart_rx: RTL and testbench

// UART receive stage; consumes the 16x-oversample enable from the baud-rate generator.

---
 rtl/uart_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   UART receive stage driven by a 16x-baud oversample enable. The serial
//   line is double-flopped, the start bit is validated at its mid-point, each
//   data/parity/stop bit is sampled at mid-period, and a good byte is parked
//   in a single-entry valid/ready output register.
//
// Parameters
//   DATA_BITS   payload bits per frame (5..8), LSB first
//   PARITY_EN   1 = one parity bit follows the data
//   PARITY_ODD  1 = odd parity, 0 = even (ignored when PARITY_EN=0)
//
// Ports
//   clk_i         in   system clock
//   rst_n_i       in   synchronous reset, active-low
//   rx_en_i       in   16x-baud oversample tick, one clk wide
//   rx_i          in   asynchronous serial line, idle high
//   data_o        out  received payload, stable while valid_o=1
//   valid_o       out  data_o holds an unconsumed byte
//   ready_i       in   consumer accepts data_o when valid_o & ready_i
//   frame_err_o   out  1-clk pulse: stop bit sampled low
//   parity_err_o  out  1-clk pulse: parity mismatch
//   overrun_o     out  1-clk pulse: good frame arrived while valid_o=1
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rx_en_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o
);

  localparam int             BCW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic                 r_sync1;
  logic                 r_sync2;
  state_t               r_state;
  logic [3:0]           r_tick_cnt;
  logic [BCW-1:0]       r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bad;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;

  // -------------------------------------------------------------------------
  // Combinational next-state
  // -------------------------------------------------------------------------
  logic                 w_rx_s;
  logic                 w_tick_end;
  logic                 w_par_exp;
  state_t               w_state_n;
  logic [3:0]           w_tick_n;
  logic [BCW-1:0]       w_bit_n;
  logic [DATA_BITS-1:0] w_shift_n;
  logic                 w_par_bad_n;
  logic                 w_stop_done;
  logic                 w_ferr;
  logic                 w_perr;
  logic                 w_good;
  logic                 w_ovr;
  logic                 w_load;

  assign w_rx_s     = r_sync2;
  assign w_tick_end = (r_tick_cnt == 4'd15);
  // Parity bit value a clean frame must carry for the bits now in r_shift.
  assign w_par_exp  = (^r_shift) ^ (PARITY_ODD != 0);

  always_comb begin
    w_state_n   = r_state;
    w_tick_n    = r_tick_cnt;
    w_bit_n     = r_bit_cnt;
    w_shift_n   = r_shift;
    w_par_bad_n = r_par_bad;
    w_stop_done = 1'b0;

    if (rx_en_i) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            w_state_n = S_START;
            w_tick_n  = 4'd0;
          end
        end

        // Start bit must still be low half a bit later; otherwise a glitch.
        S_START: begin
          if (r_tick_cnt == 4'd7) begin
            if (!w_rx_s) begin
              w_state_n   = S_DATA;
              w_tick_n    = 4'd0;
              w_bit_n     = '0;
              w_par_bad_n = 1'b0;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_tick_n = r_tick_cnt + 4'd1;
          end
        end

        // tick_cnt wraps 15->0, so every later sample lands at mid-bit.
        S_DATA: begin
          w_tick_n = r_tick_cnt + 4'd1;
          if (w_tick_end) begin
            w_shift_n[r_bit_cnt] = w_rx_s;
            if (r_bit_cnt == LAST_BIT) begin
              w_state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              w_bit_n = r_bit_cnt + 1'b1;
            end
          end
        end

        S_PARITY: begin
          w_tick_n = r_tick_cnt + 4'd1;
          if (w_tick_end) begin
            w_par_bad_n = r_par_bad | (w_rx_s != w_par_exp);
            w_state_n   = S_STOP;
          end
        end

        S_STOP: begin
          w_tick_n = r_tick_cnt + 4'd1;
          if (w_tick_end) begin
            w_stop_done = 1'b1;
            w_state_n   = S_IDLE;
          end
        end

        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // Frame resolution: a low stop bit beats a parity error; a good frame that
  // meets an unconsumed byte is an overrun unless that byte is being taken
  // this very clk, in which case the new byte simply replaces it.
  assign w_ferr = w_stop_done & ~w_rx_s;
  assign w_perr = w_stop_done &  w_rx_s &  r_par_bad;
  assign w_good = w_stop_done &  w_rx_s & ~r_par_bad;
  assign w_ovr  = w_good & r_valid & ~ready_i;
  assign w_load = w_good & ~w_ovr;

  // -------------------------------------------------------------------------
  // FSM / datapath state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= S_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_bad  <= 1'b0;
    end else begin
      r_sync1    <= rx_i;
      r_sync2    <= r_sync1;
      r_state    <= w_state_n;
      r_tick_cnt <= w_tick_n;
      r_bit_cnt  <= w_bit_n;
      r_shift    <= w_shift_n;
      r_par_bad  <= w_par_bad_n;
    end
  end

  // -------------------------------------------------------------------------
  // Output register and handshake (runs every clk)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err  <= w_ferr;
      r_parity_err <= w_perr;
      r_overrun    <= w_ovr;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign frame_err_o  = r_frame_err;
  assign parity_err_o = r_parity_err;
  assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Two receivers share clock, reset and oversample tick: u_dut0 is 8N1,
//   u_dut1 is 8E1. A frame-level model per receiver (tick counting since the
//   start edge, samples at 8 + 16*k) predicts every output every clk; a
//   negedge process compares. Directed scenarios pin the model with literal
//   values, then randomized frames exercise both receivers.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int DB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // rx_en every 4th clk
  logic [1:0] ph = 2'd0;
  logic       rx_en;
  always @(posedge clk) ph <= ph + 2'd1;
  assign rx_en = (ph == 2'd0);

  logic rst_n;
  logic rx0, rx1;
  logic rdy0_b, rdy0_l, rdy0, rdy1, land;
  assign rdy0 = land ? rdy0_l : rdy0_b;

  logic [DB-1:0] d0, d1;
  logic v0, fe0, pe0, ov0;
  logic v1, fe1, pe1, ov1;

  uart_rx #(.DATA_BITS(DB), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .rx_en_i(rx_en), .rx_i(rx0),
    .data_o(d0), .valid_o(v0), .ready_i(rdy0),
    .frame_err_o(fe0), .parity_err_o(pe0), .overrun_o(ov0)
  );

  uart_rx #(.DATA_BITS(DB), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .rx_en_i(rx_en), .rx_i(rx1),
    .data_o(d1), .valid_o(v1), .ready_i(rdy1),
    .frame_err_o(fe1), .parity_err_o(pe1), .overrun_o(ov1)
  );

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  typedef struct {
    logic          s1, s2;     // line delayed by two clks
    bit            busy;
    int            n;          // ticks since the first low tick
    logic [DB-1:0] d;
    bit            pbad;
    logic          valid;
    logic [DB-1:0] data;
    logic          fe, pe, ov;
    bit            nstop;      // next tick samples the stop bit
  } mst_t;

  mst_t m0, m1;

  task automatic model_step(inout mst_t m, input logic rst, input logic en,
                            input logic rx, input logic rdy, input int pen,
                            input bit podd);
    logic rxs;
    bit   load;
    int   k;
    rxs  = m.s2;
    m.s2 = m.s1;
    m.s1 = rx;
    m.fe = 1'b0; m.pe = 1'b0; m.ov = 1'b0;
    load = 1'b0;
    if (!rst) begin
      m.s1 = 1'b1; m.s2 = 1'b1;
      m.busy = 1'b0; m.n = 0; m.nstop = 1'b0;
      m.valid = 1'b0; m.data = '0;
      return;
    end
    if (en) begin
      if (!m.busy) begin
        if (!rxs) begin
          m.busy = 1'b1; m.n = 0; m.pbad = 1'b0;
        end
      end else begin
        m.n++;
        if (m.n == 8) begin
          if (rxs) m.busy = 1'b0;
        end else if (m.n > 8 && (m.n - 8) % 16 == 0) begin
          k = (m.n - 8) / 16;
          if (k <= DB) m.d[k-1] = rxs;
          else if (pen != 0 && k == DB + 1) m.pbad = (rxs != ((^m.d) ^ podd));
          else begin
            m.busy = 1'b0;
            if (!rxs)                m.fe = 1'b1;
            else if (m.pbad)         m.pe = 1'b1;
            else if (m.valid && !rdy) m.ov = 1'b1;
            else                     load = 1'b1;
          end
        end
      end
    end
    if (load) begin
      m.valid = 1'b1; m.data = m.d;
    end else if (m.valid && rdy) begin
      m.valid = 1'b0;
    end
    m.nstop = m.busy && (m.n + 1 == 8 + 16 * (DB + pen + 1));
  endtask

  always @(posedge clk) begin
    model_step(m0, rst_n, rx_en, rx0, rdy0, 0, 1'b0);
    model_step(m1, rst_n, rx_en, rx1, rdy1, 1, 1'b0);
  end

  // ready pulse aligned to the stop-sampling tick of u_dut0
  always @(negedge clk) rdy0_l = rx_en && m0.nstop;

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int c_fe0 = 0, c_ov0 = 0, c_pe1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dut0.data",   d0,  m0.data);
      chk("dut0.valid",  v0,  m0.valid);
      chk("dut0.ferr",   fe0, m0.fe);
      chk("dut0.perr",   pe0, m0.pe);
      chk("dut0.ovr",    ov0, m0.ov);
      chk("dut1.data",   d1,  m1.data);
      chk("dut1.valid",  v1,  m1.valid);
      chk("dut1.ferr",   fe1, m1.fe);
      chk("dut1.perr",   pe1, m1.pe);
      chk("dut1.ovr",    ov1, m1.ov);
      c_fe0 += int'(fe0);
      c_ov0 += int'(ov0);
      c_pe1 += int'(pe1);
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int w, input logic b, input int len);
    if (w == 0) rx0 = b; else rx1 = b;
    idle(len);
  endtask

  // start, DB data bits LSB first, parity (dut1 only), stop, back to idle
  task automatic send_frame(input int w, input logic [DB-1:0] d,
                            input logic pbit, input logic stopb);
    drive_bit(w, 1'b0, 64);
    for (int i = 0; i < DB; i++) drive_bit(w, d[i], 64);
    if (w == 1) drive_bit(w, pbit, 64);
    drive_bit(w, stopb, 64);
    if (w == 0) rx0 = 1'b1; else rx1 = 1'b1;
  endtask

  initial begin
    int fe_s, ov_s, pe_s;
    logic [DB-1:0] pat;
    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
    rdy0_b = 1'b0; rdy1 = 1'b0; land = 1'b0;
    idle(5);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset valid0", v0, 0);
    chk("reset data0",  d0, 0);
    chk("reset valid1", v1, 0);
    idle(40);

    // 0xA5 8N1, held until consumed
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    idle(20);
    chk("A5 valid", v0, 1);
    chk("A5 data",  d0, 8'hA5);
    idle(200);
    chk("A5 hold",  v0, 1);
    rdy0_b = 1'b1; idle(2); rdy0_b = 1'b0;
    chk("A5 consumed", v0, 0);
    chk("A5 no errors", c_fe0 + c_ov0, 0);

    // single-tick low glitch
    rx0 = 1'b0; idle(4); rx0 = 1'b1;
    idle(200);
    chk("glitch valid", v0, 0);
    chk("glitch errs",  c_fe0 + c_ov0, 0);

    // 0x3C with stop forced low
    fe_s = c_fe0;
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    idle(40);
    chk("3C ferr count", c_fe0 - fe_s, 1);
    chk("3C valid", v0, 0);

    // parity on dut1: 0x07 needs parity 1 for even parity
    pe_s = c_pe1;
    send_frame(1, 8'h07, 1'b0, 1'b1);
    idle(40);
    chk("07 perr count", c_pe1 - pe_s, 1);
    chk("07 bad valid",  v1, 0);
    send_frame(1, 8'h07, 1'b1, 1'b1);
    idle(40);
    chk("07 good valid", v1, 1);
    chk("07 good data",  d1, 8'h07);

    // overrun, then replacement landing together with ready
    ov_s = c_ov0;
    send_frame(0, 8'h11, 1'b0, 1'b1);
    idle(20);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    idle(20);
    chk("ovr count", c_ov0 - ov_s, 1);
    chk("ovr data kept", d0, 8'h11);
    land = 1'b1;
    send_frame(0, 8'h33, 1'b0, 1'b1);
    idle(20);
    land = 1'b0;
    chk("land data",  d0, 8'h33);
    chk("land valid", v0, 1);
    chk("land no ovr", c_ov0 - ov_s, 1);

    // reset during data bit 3 of 0x5A (0x33 still parked in dut0)
    pat = 8'h5A;
    drive_bit(0, 1'b0, 64);
    for (int i = 0; i < 3; i++) drive_bit(0, pat[i], 64);
    drive_bit(0, pat[3], 32);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    chk("midrst valid0", v0, 0);
    chk("midrst data0",  d0, 0);
    chk("midrst valid1", v1, 0);
    chk("midrst data1",  d1, 0);
    drive_bit(0, pat[3], 31);
    rx0 = 1'b1;
    idle(300);
    chk("post-rst quiet", v0, 0);
    send_frame(0, 8'hC3, 1'b0, 1'b1);
    idle(20);
    chk("C3 data",  d0, 8'hC3);
    chk("C3 valid", v0, 1);
    rdy0_b = 1'b1; idle(2); rdy0_b = 1'b0;

    // break on dut0: repeated frame errors
    rx0 = 1'b0; idle(1500); rx0 = 1'b1; idle(200);

    // randomized frames on both receivers
    for (int i = 0; i < 30; i++) begin : rnd
      int w;
      logic [DB-1:0] d;
      logic sb, pb;
      w  = int'($urandom % 2);
      d  = DB'($urandom);
      sb = (($urandom % 8) != 0);
      pb = (^d) ^ (($urandom % 6) == 0);
      rdy0_b = $urandom % 2;
      rdy1   = $urandom % 2;
      send_frame(w, d, pb, sb);
      idle(int'($urandom % 100));
    end

    rdy0_b = 1'b1; rdy1 = 1'b1;
    idle(20);
    chk("drain valid0", v0, 0);
    chk("drain valid1", v1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
